// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controller state encoding, opcode classes, widths.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 2;

  // Fetch/execute controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_FETCH_OP = 3'd3,
    ST_EXEC     = 3'd4,
    ST_HALT     = 3'd5
  } state_e;

  // Opcode class lives in the top two bits of the instruction byte.
  localparam logic [OP_W-1:0] OP_ALU  = 2'b00;
  localparam logic [OP_W-1:0] OP_JMP  = 2'b01;
  localparam logic [OP_W-1:0] OP_JZ   = 2'b10;
  localparam logic [OP_W-1:0] OP_HALT = 2'b11;

  // Extract the opcode class from an instruction byte.
  function automatic logic [OP_W-1:0] opcode_of(input logic [DATA_W-1:0] instr);
    return instr[DATA_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch/decode controller: fetches 1- or 2-byte instructions,
// hands ALU opcodes to the datapath and issues PC increment/load/clear.
module fetch_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              pc_clear,
  input  logic              zero_flag,
  output logic [DATA_W-1:0] ir,
  output logic              exec_valid,
  output logic              halted,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              clr_done_q;
  logic              pc_clear_q;
  logic [OP_W-1:0]   op;

  // RAM address simply follows the program counter.
  assign mem_addr = pc;
  assign ir       = ir_q;
  assign pc_clear = pc_clear_q;
  assign halted   = (state_q == ST_HALT);
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);

  // Next-state, latch enables and per-cycle PC/memory commands.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    opnd_d      = opnd_q;
    mem_rd      = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    exec_valid  = 1'b0;
    op          = opcode_of(ir_q);

    case (state_q)
      ST_IDLE: begin
        // Hold off the first fetch until the post-reset PC clear has landed.
        if (run && clr_done_q) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (op)
          OP_ALU: begin
            exec_valid = 1'b1;
            state_d    = run ? ST_FETCH : ST_IDLE;
          end
          OP_HALT: state_d = ST_HALT;
          default: state_d = ST_FETCH_OP;
        endcase
      end

      ST_FETCH_OP: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          opnd_d  = mem_rdata;
          // JMP is about to overwrite the PC, so skipping past the operand is wasted.
          pc_inc  = (op == OP_JZ);
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if ((op == OP_JMP) || ((op == OP_JZ) && zero_flag)) begin
          pc_load     = 1'b1;
          pc_load_val = opnd_q;
        end
        state_d = run ? ST_FETCH : ST_IDLE;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_IDLE;
    endcase
  end

  // State, instruction/operand registers and the one-shot PC clear after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      opnd_q     <= '0;
      clr_done_q <= 1'b0;
      pc_clear_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      opnd_q     <= opnd_d;
      clr_done_q <= 1'b1;
      pc_clear_q <= ~clr_done_q;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: an ISA-level interpreter predicts the
// sequence of fetches, executes, loads and halts; a monitor checks the DUT.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] pc_m = 8'hA5;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       pc_inc, pc_load, pc_clear;
  logic [7:0] pc_load_val;
  logic       zero_flag = 1'b0;
  logic [7:0] ir;
  logic       exec_valid, halted, busy;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .pc          (pc_m),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .pc_clear    (pc_clear),
    .zero_flag   (zero_flag),
    .ir          (ir),
    .exec_valid  (exec_valid),
    .halted      (halted),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Program counter that obeys the controller's commands.
  always @(posedge clk) begin
    if (pc_clear)     pc_m <= 8'h00;
    else if (pc_load) pc_m <= pc_load_val;
    else if (pc_inc)  pc_m <= pc_m + 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm, input string what);
    n_checks++;
    $display("FAIL %s: got %s (t=%0t)", nm, what, $time);
  endtask

  // Expected-event scoreboard.
  typedef enum logic [2:0] {EV_FOP, EV_FJMP, EV_FJZ, EV_EXEC, EV_LOAD, EV_HALT} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] val;
  } ev_t;
  ev_t exp_q[$];

  // Interpret k instructions from address 0; returns queue depth at which the
  // last instruction's opcode fetch has been seen, and the final PC.
  task automatic build_model(input int k, input bit z, output int drop_sz,
                             output bit last_halt, output logic [7:0] fpc);
    logic [7:0] p;
    logic [7:0] opc;
    logic [7:0] t;
    int n_before;
    p = 8'h00;
    n_before = 0;
    last_halt = 1'b0;
    exp_q.delete();
    for (int i = 0; i < k; i++) begin
      n_before = exp_q.size();
      opc = mem[p];
      exp_q.push_back('{EV_FOP, p});
      p = p + 8'd1;
      case (opc[7:6])
        2'b00: exp_q.push_back('{EV_EXEC, opc});
        2'b01: begin
          exp_q.push_back('{EV_FJMP, p});
          t = mem[p];
          exp_q.push_back('{EV_LOAD, t});
          p = t;
        end
        2'b10: begin
          exp_q.push_back('{EV_FJZ, p});
          t = mem[p];
          p = p + 8'd1;
          if (z) begin
            exp_q.push_back('{EV_LOAD, t});
            p = t;
          end
        end
        default: begin
          exp_q.push_back('{EV_HALT, 8'h00});
          last_halt = 1'b1;
        end
      endcase
      if (last_halt) break;
    end
    drop_sz = exp_q.size() - n_before - 1;
    fpc = p;
  endtask

  // Memory responder: random or fixed wait states, spurious ready when idle.
  int wait_mode = -1;
  int wait_left = -1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_rd) begin
        if (wait_left < 0) wait_left = (wait_mode < 0) ? int'($urandom_range(3, 0)) : wait_mode;
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr];
          wait_left = -1;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 8'($urandom);
          wait_left--;
        end
      end else begin
        wait_left = -1;
        mem_ready = ($urandom_range(2, 0) == 0);
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Monitor: per-cycle invariants plus in-order event matching.
  logic [7:0] prev_ir = 8'h00;
  bit prev_hs = 1'b0;
  bit prev_halted = 1'b0;
  int first_rd_cyc = -1, rd_run = 0, first_rd_len = -1;
  int prev_exec_cyc = -1, exec_gap = -1, load_cyc = -1;
  int inc_count = 0, inc_at_load = -1;

  initial begin : mon
    ev_t e;
    bit  hs;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ir = ir; prev_hs = 1'b0; prev_halted = 1'b0;
        first_rd_cyc = -1; rd_run = 0; first_rd_len = -1;
        prev_exec_cyc = -1; exec_gap = -1; load_cyc = -1;
        inc_count = 0; inc_at_load = -1;
      end else begin
        hs = mem_rd && mem_ready;
        check("mem_addr", 32'(mem_addr), 32'(pc_m));
        check("pc_cmd_single", 32'((32'(pc_inc) + 32'(pc_load) + 32'(pc_clear)) <= 32'd1), 32'd1);
        if (!pc_load) check("load_val_idle", 32'(pc_load_val), 32'd0);
        if (pc_inc) check("inc_on_handshake", 32'(hs), 32'd1);
        if (halted) check("halt_quiet", 32'({mem_rd, busy}), 32'd0);
        if (ir != prev_ir) check("ir_on_handshake", 32'(prev_hs), 32'd1);
        if (mem_rd) begin
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          rd_run++;
        end
        if (pc_inc) inc_count++;

        if (hs) begin
          if (first_rd_len < 0) first_rd_len = rd_run;
          rd_run = 0;
          if (exp_q.size() == 0) fail_now("unexpected_fetch", "a fetch, expected none");
          else begin
            e = exp_q.pop_front();
            check("event_is_fetch", 32'(e.kind), (e.kind == EV_FJMP || e.kind == EV_FJZ) ? 32'(e.kind) : 32'(EV_FOP));
            check("fetch_addr", 32'(mem_addr), 32'(e.val));
            check("fetch_pc_inc", 32'(pc_inc), 32'(e.kind != EV_FJMP));
          end
        end
        if (exec_valid) begin
          if (prev_exec_cyc >= 0) exec_gap = cyc - prev_exec_cyc;
          prev_exec_cyc = cyc;
          if (exp_q.size() == 0) fail_now("unexpected_exec", "exec_valid, expected none");
          else begin
            e = exp_q.pop_front();
            check("exec_kind", 32'(EV_EXEC), 32'(e.kind));
            check("exec_ir", 32'(ir), 32'(e.val));
          end
        end
        if (pc_load) begin
          load_cyc = cyc;
          inc_at_load = inc_count;
          if (exp_q.size() == 0) fail_now("unexpected_load", "pc_load, expected none");
          else begin
            e = exp_q.pop_front();
            check("load_kind", 32'(EV_LOAD), 32'(e.kind));
            check("load_val", 32'(pc_load_val), 32'(e.val));
          end
        end
        if (halted && !prev_halted) begin
          if (exp_q.size() == 0) fail_now("unexpected_halt", "halted, expected none");
          else begin
            e = exp_q.pop_front();
            check("halt_kind", 32'(EV_HALT), 32'(e.kind));
            check("halt_busy", 32'(busy), 32'd0);
          end
        end
        prev_ir = ir;
        prev_hs = hs;
        prev_halted = halted;
      end
    end
  end

  task automatic check_reset_outs();
    check("rst_outs", 32'({mem_rd, pc_inc, pc_load, pc_clear, exec_valid, halted, busy}), 32'd0);
    check("rst_load_val", 32'(pc_load_val), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'(pc_m));
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int a = 0; a < 256; a++) mem[a] = v;
  endtask

  task automatic fill_random();
    int r;
    logic [1:0] o;
    for (int a = 0; a < 256; a++) begin
      r = int'($urandom_range(9, 0));
      o = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      mem[a] = {o, 6'($urandom)};
    end
  endtask

  // Reset, release with run=1, follow the program, drop run during the last instruction.
  task automatic run_seg(input int k, input bit z, input int wm);
    int drop_sz;
    bit last_halt;
    logic [7:0] fpc;
    int guard;
    #1 reset = 1'b1; run = 1'b0;
    #1 check_reset_outs();
    zero_flag = z;
    wait_mode = wm;
    build_model(k, z, drop_sz, last_halt, fpc);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0; run = 1'b1;
    @(negedge clk);
    check("pc_clear_first", 32'(pc_clear), 32'd1);
    @(negedge clk);
    check("pc_clear_once", 32'(pc_clear), 32'd0);
    guard = 0;
    while (exp_q.size() > drop_sz && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    #1 run = 1'b0;
    if (guard >= 3000) fail_now("timeout_drop", "no progress, expected last opcode fetch");
    guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 3000) fail_now("timeout_drain", "pending events, expected none");
    repeat (12) @(negedge clk);
    if (last_halt) check("end_halted", 32'({halted, busy, mem_rd}), 32'b100);
    else           check("end_idle", 32'({halted, busy, mem_rd}), 32'b000);
    check("end_pc", 32'(pc_m), 32'(fpc));
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int guard;
    int drop_sz;
    bit last_halt;
    logic [7:0] fpc;

    // Two ALU instructions back to back, zero wait.
    fill_const(8'hC0);
    mem[0] = 8'h05; mem[1] = 8'h06;
    run_seg(2, 1'b0, 0);
    check("alu_exec_gap", 32'(exec_gap), 32'd2);

    // JMP 0x20: load in the fourth cycle, single increment.
    fill_const(8'hC0);
    mem[0] = 8'h40; mem[1] = 8'h20;
    run_seg(2, 1'b0, 0);
    check("jmp_latency", 32'(load_cyc - first_rd_cyc), 32'd3);
    check("jmp_inc_count", 32'(inc_at_load), 32'd1);

    // JZ taken and not taken.
    fill_const(8'hC0);
    mem[0] = 8'h80; mem[1] = 8'h10;
    run_seg(2, 1'b1, 0);
    run_seg(2, 1'b0, 0);

    // Three wait states on the opcode fetch.
    fill_const(8'hC0);
    mem[0] = 8'h05;
    run_seg(2, 1'b0, 3);
    check("stall_rd_len", 32'(first_rd_len), 32'd4);

    // JZ at 0xFF takes its operand from 0x00.
    fill_const(8'hC0);
    mem[0] = 8'h40; mem[1] = 8'hFF; mem[8'hFF] = 8'h80;
    run_seg(3, 1'b0, -1);
    mem[0] = 8'h40; mem[1] = 8'hFF; mem[8'hFF] = 8'h80;
    run_seg(3, 1'b1, -1);

    // Reset while the JMP operand read is stalled.
    fill_const(8'hC0);
    mem[0] = 8'h40; mem[1] = 8'h33;
    #1 reset = 1'b1; run = 1'b0;
    wait_mode = 8;
    build_model(1, 1'b0, drop_sz, last_halt, fpc);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0; run = 1'b1;
    guard = 0;
    while (exp_q.size() > 2 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 500) fail_now("timeout_opfetch", "no opcode fetch, expected one");
    repeat (3) @(negedge clk);
    check("stalled_fetch_op", 32'({mem_rd, busy}), 32'b11);
    #1 reset = 1'b1;
    #1 check_reset_outs();
    exp_q.delete();

    // Random programs, random zero flag and wait states.
    for (int s = 0; s < 20; s++) begin
      fill_random();
      run_seg(int'($urandom_range(30, 4)), 1'($urandom_range(1, 0)),
              ($urandom_range(1, 0) == 0) ? -1 : int'($urandom_range(2, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
